// File: rtl/target_eat_detect.sv
// Target placement and eat detection for the snake game: validates random
// addresses from the generator, arms a target, and scores when the head lands on it.
module target_eat_detect #(
    parameter int unsigned MAX_X         = 160,
    parameter int unsigned MAX_Y         = 120,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned WIN_SCORE     = 10
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [14:0] RND_ADDR,
    input  logic [7:0]  HEAD_X,
    input  logic [6:0]  HEAD_Y,
    input  logic        HEAD_STEP,
    output logic        TARGET_ATE,
    output logic [7:0]  TARGET_X,
    output logic [6:0]  TARGET_Y,
    output logic        TARGET_VALID,
    output logic [7:0]  SCORE,
    output logic        GAME_WIN
);

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        CHECK  = 2'd1,
        ARMED  = 2'd2,
        EAT    = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  settle_cnt;
    logic [14:0] cand;
    logic        reject_c;
    logic        head_hit_c;

    // Candidate is unusable if off-field or under the live head position.
    always_comb begin
        reject_c = (32'(cand[14:7]) >= MAX_X) ||
                   (32'(cand[6:0])  >= MAX_Y) ||
                   (cand == {HEAD_X, HEAD_Y});
    end

    always_comb begin
        head_hit_c = HEAD_STEP && (HEAD_X == TARGET_X) && (HEAD_Y == TARGET_Y);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= SETTLE;
            settle_cnt   <= CNT_LOAD;
            cand         <= 15'd0;
            TARGET_ATE   <= 1'b0;
            TARGET_X     <= 8'd0;
            TARGET_Y     <= 7'd0;
            TARGET_VALID <= 1'b0;
            SCORE        <= 8'd0;
            GAME_WIN     <= 1'b0;
        end else begin
            TARGET_ATE <= 1'b0;
            if (32'(SCORE) >= WIN_SCORE) begin
                GAME_WIN <= 1'b1;
            end

            case (state)
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        cand  <= RND_ADDR;
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    if (reject_c) begin
                        TARGET_ATE <= 1'b1;
                        settle_cnt <= CNT_LOAD;
                        state      <= SETTLE;
                    end else begin
                        TARGET_X     <= cand[14:7];
                        TARGET_Y     <= cand[6:0];
                        TARGET_VALID <= 1'b1;
                        state        <= ARMED;
                    end
                end
                ARMED: begin
                    // Eat effects become visible during the single EAT cycle.
                    if (head_hit_c) begin
                        TARGET_VALID <= 1'b0;
                        TARGET_ATE   <= 1'b1;
                        if (SCORE != 8'hFF) begin
                            SCORE <= SCORE + 8'd1;
                        end
                        state <= EAT;
                    end
                end
                EAT: begin
                    settle_cnt <= CNT_LOAD;
                    state      <= SETTLE;
                end
                default: begin
                    settle_cnt <= CNT_LOAD;
                    state      <= SETTLE;
                end
            endcase
        end
    end

endmodule

// File: doc/target_eat_detect.md
TARGET_EAT_DETECT -- requirements
Module: target_eat_detect

Interface
REQ-001 The block SHALL expose parameter MAX_X, default 160, meaning the exclusive upper bound of a legal target X.
REQ-002 The block SHALL expose parameter MAX_Y, default 120, meaning the exclusive upper bound of a legal target Y.
REQ-003 The block SHALL expose parameter SETTLE_CYCLES, default 2 (legal range 1..15), meaning the number of cycles to wait after a request before sampling RND_ADDR.
REQ-004 The block SHALL expose parameter WIN_SCORE, default 10, meaning the score value that asserts GAME_WIN.
REQ-005 The block SHALL have port CLK, input, 1 bit: system clock; all logic is rising-edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: one clock; reset is synchronous and active-high.
REQ-007 The block SHALL have port RND_ADDR, input, 15 bits: the random address from the target generator; [14:7] = X, [6:0] = Y.
REQ-008 The block SHALL have port HEAD_X, input, 8 bits: the snake head X.
REQ-009 The block SHALL have port HEAD_Y, input, 7 bits: the snake head Y.
REQ-010 The block SHALL have port HEAD_STEP, input, 1 bit: a 1-cycle pulse meaning HEAD_X/HEAD_Y hold a new position.
REQ-011 The block SHALL have port TARGET_ATE, output, 1 bit: a 1-cycle pulse requesting a new address from the generator.
REQ-012 The block SHALL have port TARGET_X, output, 8 bits: the current target X.
REQ-013 The block SHALL have port TARGET_Y, output, 7 bits: the current target Y.
REQ-014 The block SHALL have port TARGET_VALID, output, 1 bit: high while the target is placed and eatable.
REQ-015 The block SHALL have port SCORE, output, 8 bits: the number of targets eaten, saturating.
REQ-016 The block SHALL have port GAME_WIN, output, 1 bit: sticky, high once SCORE >= WIN_SCORE.

Function
REQ-017 The FSM SHALL have states SETTLE, CHECK, ARMED and EAT, encoded in 2 bits.
REQ-018 SETTLE SHALL load a 4-bit counter with SETTLE_CYCLES-1 on entry and decrement it each cycle; when the counter is 0 it SHALL capture RND_ADDR into a candidate register and go to CHECK.
REQ-019 CHECK SHALL reject a candidate when X >= MAX_X, when Y >= MAX_Y, or when the candidate equals {HEAD_X, HEAD_Y}.
REQ-020 On rejection, CHECK SHALL pulse TARGET_ATE for 1 cycle and go to SETTLE (retry); retries are unbounded.
REQ-021 On acceptance, CHECK SHALL load TARGET_X/TARGET_Y from the candidate, set TARGET_VALID=1 and go to ARMED.
REQ-022 In ARMED, when HEAD_STEP=1 and {HEAD_X, HEAD_Y} == {TARGET_X, TARGET_Y}, the block SHALL go to EAT; the comparison SHALL be evaluated only on HEAD_STEP cycles.
REQ-023 In EAT (exactly 1 cycle), the block SHALL clear TARGET_VALID, pulse TARGET_ATE, increment SCORE (saturating at 255) and go to SETTLE.
REQ-024 SCORE SHALL not wrap: 255 + 1 = 255.
REQ-025 TARGET_ATE SHALL be registered, SHALL be high for exactly one cycle per request, and SHALL never be high on two consecutive cycles.
REQ-026 HEAD_STEP asserted in SETTLE, CHECK or EAT SHALL be ignored for eating; in CHECK, the head comparison SHALL use the live HEAD_X/HEAD_Y.
REQ-027 GAME_WIN SHALL be set in the cycle after SCORE first reaches WIN_SCORE and SHALL stay high until RESET; scoring SHALL continue after GAME_WIN.
REQ-028 TARGET_X/TARGET_Y SHALL hold their last accepted value while TARGET_VALID=0.

Reset
REQ-029 While RESET=1, the block SHALL set state=SETTLE, counter=SETTLE_CYCLES-1, TARGET_ATE=0, TARGET_X=0, TARGET_Y=0, TARGET_VALID=0, SCORE=0 and GAME_WIN=0.
REQ-030 After reset, the first placement SHALL sample RND_ADDR without a TARGET_ATE pulse.
REQ-031 A RESET asserted in any state, including mid-EAT, SHALL abort the operation, and no TARGET_ATE pulse or SCORE increment SHALL be issued in that cycle.

Verification
REQ-032 Reset release with RND_ADDR = {8'd40, 7'd30}, SETTLE_CYCLES = 2 -> TARGET_VALID=1 with X=40, Y=30 three cycles after release, and no TARGET_ATE pulse.
REQ-033 Head at (40,30) with a HEAD_STEP pulse while ARMED -> next cycle TARGET_ATE=1 for 1 cycle, TARGET_VALID=0, SCORE 0->1; a new target is accepted after settle.
REQ-034 RND_ADDR X=200 and then Y=127 -> each value produces a TARGET_ATE retry pulse with TARGET_VALID held 0; a third legal value (10,10) is accepted.
REQ-035 Candidate equal to the current head position -> rejected with a retry pulse; a head equal to the target without HEAD_STEP -> no eat.
REQ-036 Eat WIN_SCORE=10 targets -> GAME_WIN rises after the 10th eat; force 260 eats -> SCORE stays at 255.
REQ-037 RESET asserted on the EAT cycle -> TARGET_ATE=0, SCORE=0, state=SETTLE on the following cycle.
